// File: rtl/pcont_ibuf_pkg.sv
// Shared ISA symbols for the fetch path: mode encoding, NOP words and the
// M16 halfword-to-internal-form expansion.
package pcont_ibuf_pkg;

  typedef enum logic {
    M32 = 1'b0,
    M16 = 1'b1
  } isa_mode_e;

  localparam logic [31:0] M32_NOP      = 32'h0000_0000;
  localparam logic [15:0] M16_HALF_NOP = 16'h6500;

  // Internal form: {h[15], 1'b0, h[14:11], 10'b0, h[15:0]}
  function automatic logic [31:0] m16_expand(input logic [15:0] h);
    return {h[15], 1'b0, h[14:11], 10'b0, h};
  endfunction

  localparam logic [31:0] M16_NOP = {M16_HALF_NOP[15], 1'b0, M16_HALF_NOP[14:11],
                                     10'b0, M16_HALF_NOP};

  function automatic logic [31:0] nop_of(input isa_mode_e m);
    return (m == M32) ? M32_NOP : M16_NOP;
  endfunction

endpackage

// File: rtl/pcont_ibuf_if.sv
// Fetch-word handshake between the I-cache return path and the prefetch buffer.
interface pcont_ibuf_if;
  import pcont_ibuf_pkg::*;

  logic        valid;
  logic [31:0] data;
  logic        ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pcont_m16_expand.sv
// Combinational M16 halfword to 32-bit internal-form expander.
module pcont_m16_expand
  import pcont_ibuf_pkg::*;
(
  input  logic [15:0] half_i,
  output logic [31:0] inst_o
);

  always_comb begin
    inst_o = m16_expand(half_i);
  end

endmodule

// File: rtl/pcont_ibuf.sv
// Instruction prefetch buffer feeding the SF-stage instruction register,
// issuing one M32 word or one expanded M16 halfword per cycle.
module pcont_ibuf
  import pcont_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             SYSCLK,
  input  logic             RESET_D1_R,
  input  logic             CP0_INSTM32_I_R_N,
  pcont_ibuf_if.slave      fetch,
  input  logic             CLMI_FLUSH,
  input  logic             CLMI_FLUSH_B1,
  input  logic             CLMI_RHOLD,
  output logic [31:0]      INST_S_R,
  output logic             INST_VALID_S_R,
  output logic             INST_MODE_S_R,
  output logic [CNT_W-1:0] COUNT_O
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hp_q, hp_d;
  isa_mode_e        mode_q, mode_d;
  logic [31:0]      inst_q, inst_d;
  logic             inst_valid_q, inst_valid_d;
  isa_mode_e        inst_mode_q, inst_mode_d;

  logic             push;
  logic             pop;
  logic [31:0]      head;
  logic [15:0]      half;
  logic [31:0]      half_exp;
  isa_mode_e        flush_mode;

  assign head       = mem_q[rd_ptr_q];
  assign half       = hp_q ? head[15:0] : head[31:16];
  assign flush_mode = isa_mode_e'(CP0_INSTM32_I_R_N);

  pcont_m16_expand u_expand (
    .half_i (half),
    .inst_o (half_exp)
  );

  // Ready depends only on occupancy and flush/reset, never on the incoming valid.
  assign fetch.ready = !RESET_D1_R && !CLMI_FLUSH && (count_q < CNT_W'(DEPTH));
  assign push        = fetch.valid && fetch.ready;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    hp_d         = hp_q;
    mode_d       = mode_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_mode_d  = inst_mode_q;
    pop          = 1'b0;

    if (CLMI_FLUSH) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      mode_d       = flush_mode;
      hp_d         = (flush_mode == M16) ? CLMI_FLUSH_B1 : 1'b0;
      inst_d       = nop_of(flush_mode);
      inst_valid_d = 1'b0;
      inst_mode_d  = flush_mode;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = fetch.data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (!CLMI_RHOLD) begin
        inst_mode_d = mode_q;
        if (count_q == '0) begin
          inst_d       = nop_of(mode_q);
          inst_valid_d = 1'b0;
        end else if (mode_q == M32) begin
          inst_d       = head;
          inst_valid_d = 1'b1;
          pop          = 1'b1;
        end else begin
          inst_d       = half_exp;
          inst_valid_d = 1'b1;
          hp_d         = !hp_q;
          pop          = hp_q;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hp_q         <= 1'b0;
      mode_q       <= M32;
      inst_q       <= M32_NOP;
      inst_valid_q <= 1'b0;
      inst_mode_q  <= M32;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hp_q         <= hp_d;
      mode_q       <= mode_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_mode_q  <= inst_mode_d;
    end
  end

  assign INST_S_R       = inst_q;
  assign INST_VALID_S_R = inst_valid_q;
  assign INST_MODE_S_R  = inst_mode_q;
  assign COUNT_O        = count_q;

  a_no_push_when_full : assert property (@(posedge SYSCLK) disable iff (RESET_D1_R)
    !(push && count_q == CNT_W'(DEPTH)));

  a_no_b1_in_m32 : assert property (@(posedge SYSCLK) disable iff (RESET_D1_R)
    !(CLMI_FLUSH && flush_mode == M32 && CLMI_FLUSH_B1));

endmodule

// File: tb/tb_pcont_ibuf.sv
// Bench for pcont_ibuf: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_pcont_ibuf;
  import pcont_ibuf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, cp_mode, flush, b1, hold;
  logic [31:0]      inst;
  logic             inst_valid, inst_mode;
  logic [CNT_W-1:0] count;

  pcont_ibuf_if bus ();

  pcont_ibuf #(.DEPTH(DEPTH)) dut (
    .SYSCLK            (clk),
    .RESET_D1_R        (rst),
    .CP0_INSTM32_I_R_N (cp_mode),
    .fetch             (bus.slave),
    .CLMI_FLUSH        (flush),
    .CLMI_FLUSH_B1     (b1),
    .CLMI_RHOLD        (hold),
    .INST_S_R          (inst),
    .INST_VALID_S_R    (inst_valid),
    .INST_MODE_S_R     (inst_mode),
    .COUNT_O           (count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic        m_hp;
  logic        m_mode;
  logic [31:0] e_inst;
  logic        e_valid;
  logic        e_imode;

  function automatic logic [31:0] ref_expand(input logic [15:0] h);
    logic [31:0] w;
    w = (32'(h) >> 15) << 31;
    w = w | ((32'(h) >> 11) & 32'hF) * 32'h0400_0000;
    w = w + 32'(h);
    return w;
  endfunction

  function automatic logic [31:0] ref_nop(input logic m);
    return m ? ref_expand(16'h6500) : 32'h0000_0000;
  endfunction

  function automatic logic ref_ready();
    return !rst && !flush && (mq.size() < DEPTH);
  endfunction

  task automatic idle();
    rst = 1'b0; cp_mode = 1'b0; flush = 1'b0; b1 = 1'b0; hold = 1'b0;
    bus.valid = 1'b0; bus.data = '0;
  endtask

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic step();
    logic        acc;
    logic [31:0] w;
    logic [15:0] h;
    if (rst) begin
      mq.delete(); m_hp = 1'b0; m_mode = 1'b0;
      e_inst = 32'h0; e_valid = 1'b0; e_imode = 1'b0;
    end else if (flush) begin
      mq.delete(); m_mode = cp_mode; m_hp = cp_mode ? b1 : 1'b0;
      e_inst = ref_nop(m_mode); e_valid = 1'b0; e_imode = m_mode;
    end else begin
      acc = bus.valid && (mq.size() < DEPTH);
      if (!hold) begin
        e_imode = m_mode;
        if (mq.size() == 0) begin
          e_inst = ref_nop(m_mode); e_valid = 1'b0;
        end else if (!m_mode) begin
          e_inst = mq.pop_front(); e_valid = 1'b1;
        end else begin
          w = mq[0];
          h = m_hp ? w[15:0] : w[31:16];
          e_inst = ref_expand(h); e_valid = 1'b1;
          if (m_hp) void'(mq.pop_front());
          m_hp = !m_hp;
        end
      end
      if (acc) mq.push_back(bus.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step(); step();
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_cmp++; if (inst !== 32'h0000_0000) begin n_fail++; $display("FAIL reset_inst: got %h want 00000000", inst); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst_mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", inst_mode); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    rst = 1'b0; #1;
    n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_m32_basic();
    idle(); bus.valid = 1'b1; bus.data = 32'h2401_0005; step(); bus.valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL m32_count1: got %0d want 1", count); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL m32_nobypass: got %b want 0", inst_valid); end
    step();
    n_cmp++; if (inst !== 32'h2401_0005) begin n_fail++; $display("FAIL m32_inst: got %h want 24010005", inst); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL m32_valid: got %b want 1", inst_valid); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL m32_count0: got %0d want 0", count); end
  endtask

  task automatic test_bubble();
    idle(); step();
    n_cmp++; if (inst !== 32'h0000_0000) begin n_fail++; $display("FAIL bubble_inst: got %h want 00000000", inst); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", inst_valid); end
  endtask

  task automatic test_m16_pair();
    idle(); flush = 1'b1; cp_mode = 1'b1; step(); flush = 1'b0;
    n_cmp++; if (inst !== 32'h3000_6500) begin n_fail++; $display("FAIL m16_flush_nop: got %h want 30006500", inst); end
    n_cmp++; if (inst_mode !== 1'b1) begin n_fail++; $display("FAIL m16_flush_mode: got %b want 1", inst_mode); end
    bus.valid = 1'b1; bus.data = 32'hE8A0_6501; step(); bus.valid = 1'b0; step();
    n_cmp++; if (inst !== 32'hB400_E8A0) begin n_fail++; $display("FAIL m16_upper: got %h want b400e8a0", inst); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL m16_count_mid: got %0d want 1", count); end
    step();
    n_cmp++; if (inst !== 32'h3000_6501) begin n_fail++; $display("FAIL m16_lower: got %h want 30006501", inst); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL m16_count_end: got %0d want 0", count); end
    step();
    n_cmp++; if (inst !== 32'h3000_6500 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL m16_bubble: got %h/%b want 30006500/0", inst, inst_valid); end
  endtask

  task automatic test_m16_b1();
    idle(); flush = 1'b1; cp_mode = 1'b1; b1 = 1'b1; step(); idle();
    bus.valid = 1'b1; bus.data = 32'h1234_ABCD; step(); bus.valid = 1'b0; step();
    n_cmp++; if (inst !== 32'h9400_ABCD) begin n_fail++; $display("FAIL m16_b1_inst: got %h want 9400abcd", inst); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL m16_b1_count: got %0d want 0", count); end
  endtask

  task automatic test_fill_hold();
    idle(); flush = 1'b1; step(); flush = 1'b0;
    hold = 1'b1; bus.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data = 32'hA000_0000 + 32'(i); #1;
      n_cmp++; if (bus.ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready%0d: got %b want %b", i, bus.ready, (i < 4)); end
      step();
    end
    bus.valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    n_cmp++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL fill_inst_held: got %h/%b want 00000000/0", inst, inst_valid); end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (inst !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL drain_inst%0d: got %h want %h", i, inst, 32'hA000_0000 + 32'(i)); end
      n_cmp++; if (count !== CNT_W'(3 - i) || bus.ready !== 1'b1) begin n_fail++; $display("FAIL drain_count%0d: got %0d/%b want %0d/1", i, count, bus.ready, 3 - i); end
    end
  endtask

  task automatic test_flush_hold();
    idle(); hold = 1'b1; bus.valid = 1'b1; bus.data = 32'h5555_0001; step(); step();
    flush = 1'b1; bus.data = 32'h5555_0002; #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.ready); end
    step(); idle();
    n_cmp++; if (count !== '0 || inst !== 32'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_state: got %0d/%h/%b want 0/00000000/0", count, inst, inst_valid); end
    step();
    n_cmp++; if (inst_valid !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL flush_dropped: got %b/%0d want 0/0", inst_valid, count); end
  endtask

  task automatic test_reset_mid_pair();
    idle(); flush = 1'b1; cp_mode = 1'b1; step(); idle();
    bus.valid = 1'b1; bus.data = 32'h7777_8888; step(); bus.valid = 1'b0; step();
    rst = 1'b1; bus.valid = 1'b1; step(); idle();
    n_cmp++; if (inst !== 32'h0 || inst_mode !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL midpair_reset: got %h/%b/%0d want 00000000/0/0", inst, inst_mode, count); end
    bus.valid = 1'b1; bus.data = 32'h1111_2222; step(); bus.valid = 1'b0; step();
    n_cmp++; if (inst !== 32'h1111_2222 || inst_mode !== 1'b0) begin n_fail++; $display("FAIL midpair_m32: got %h/%b want 11112222/0", inst, inst_mode); end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(63) == 0);
      flush     = ($urandom_range(15) == 0);
      cp_mode   = $urandom_range(1);
      b1        = cp_mode ? 1'($urandom_range(1)) : 1'b0;
      hold      = ($urandom_range(3) == 0);
      bus.valid = $urandom_range(1);
      bus.data  = $urandom;
      #1;
      n_cmp++; if (bus.ready !== ref_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", i, bus.ready, ref_ready()); end
      step();
      n_cmp++; if (inst !== e_inst) begin n_fail++; $display("FAIL rnd_inst@%0d: got %h want %h", i, inst, e_inst); end
      n_cmp++; if (inst_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, inst_valid, e_valid); end
      n_cmp++; if (inst_mode !== e_imode) begin n_fail++; $display("FAIL rnd_mode@%0d: got %b want %b", i, inst_mode, e_imode); end
      n_cmp++; if (count !== CNT_W'(mq.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, mq.size()); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_m32_basic();
    test_bubble();
    test_m16_pair();
    test_m16_b1();
    test_fill_hold();
    test_flush_hold();
    test_reset_mid_pair();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
